pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the 32-bit ripple adder in the processor datapath.
- Splits a WIDTH-bit add/subtract into STAGES carry-ripple segments, one segment per clock.
- Uses valid/ready handshakes on both sides, so the ALU and the multi-cycle units can stall it.
- Produces sum, carry-out, signed overflow and zero flags.

---
 rtl/pipelined_addsub_pkg.sv | 12 +
 rtl/adder_seg.sv | 25 ++
 rtl/pipelined_addsub.sv | 149 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry and opcode encoding.
package pipelined_addsub_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

endpackage

// File: rtl/adder_seg.sv
// SEG-bit ripple-carry segment built from full-adder cells; exposes the carry into its MSB for overflow.
module adder_seg #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES ripple segments, one per clock, with
// bubble-collapsing valid/ready handshakes on both sides.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  op_e              op;
  logic [WIDTH-1:0] bb_in;
  logic             c0;

  // Subtraction is a + ~b + ~cin, so cin behaves as an active-high borrow-in.
  assign op    = op_e'(sub);
  assign bb_in = (op == SUB) ? ~b : b;
  assign c0    = (op == SUB) ? ~cin : cin;

  logic [STAGES-1:0]            valid_r;
  logic [STAGES-1:0]            carry_r;
  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] bb_r;
  logic [STAGES-1:0][WIDTH-1:0] sum_r;
  logic                         cmsb_r;
  logic                         zero_r;

  logic [STAGES-1:0]            load;
  logic [STAGES-1:0]            move;
  logic [STAGES-1:0][WIDTH-1:0] a_src;
  logic [STAGES-1:0][WIDTH-1:0] bb_src;
  logic [STAGES-1:0][WIDTH-1:0] sum_src;
  logic [STAGES-1:0][WIDTH-1:0] sum_nxt;
  logic [STAGES-1:0]            c_src;
  logic [STAGES-1:0]            c_out;
  logic [STAGES-1:0]            c_msb;

  // The recursive advance rule flattened: a stage moves unless every stage
  // downstream of it is full and the output is not being taken.
  always_comb begin
    logic blocked;
    blocked = ~out_ready;
    move    = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      move[LAST-i] = valid_r[LAST-i] & ~blocked;
      blocked      = blocked & valid_r[LAST-i];
    end
  end

  assign in_ready = ~valid_r[0] | move[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int unsigned k = 1; k < STAGES; k++) begin
      load[k] = move[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] seg_sum;

    if (k == 0) begin : g_head
      assign a_src[k]   = a;
      assign bb_src[k]  = bb_in;
      assign c_src[k]   = c0;
      assign sum_src[k] = '0;
    end else begin : g_body
      assign a_src[k]   = a_r[k-1];
      assign bb_src[k]  = bb_r[k-1];
      assign c_src[k]   = carry_r[k-1];
      assign sum_src[k] = sum_r[k-1];
    end

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_src[k][k*SEG +: SEG]),
      .b    (bb_src[k][k*SEG +: SEG]),
      .cin  (c_src[k]),
      .s    (seg_sum),
      .cout (c_out[k]),
      .cmsb (c_msb[k])
    );

    // Bits above the segments already computed are still zero, so OR inserts this one.
    assign sum_nxt[k] = sum_src[k] | (WIDTH'(seg_sum) << (k * SEG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      carry_r <= '0;
      a_r     <= '0;
      bb_r    <= '0;
      sum_r   <= '0;
      cmsb_r  <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_r[k] <= 1'b1;
          a_r[k]     <= a_src[k];
          bb_r[k]    <= bb_src[k];
          sum_r[k]   <= sum_nxt[k];
          carry_r[k] <= c_out[k];
        end else if (move[k]) begin
          valid_r[k] <= 1'b0;
        end
      end
      // zero is registered so it reads 0 out of reset rather than reflecting the cleared sum.
      if (load[LAST]) begin
        cmsb_r <= c_msb[LAST];
        zero_r <= (sum_nxt[LAST] == '0);
      end
    end
  end

  assign out_valid = valid_r[LAST];
  assign z         = sum_r[LAST];
  assign cout      = carry_r[LAST];
  assign ovf       = carry_r[LAST] ^ cmsb_r;
  assign zero      = zero_r;

  logic unused;
  assign unused = ^{a_r, bb_r, c_msb};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed flag cases, random streams with stalls, mid-stream reset, and a
// single-stage 8-bit instance, all checked against an arithmetic reference model.
module tb_pipelined_addsub;
  import pipelined_addsub_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, z;

  logic         in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]   a8, b8, z8;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .z(z8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct packed {
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Plain integer arithmetic: unsigned result for z/cout, signed result for ovf.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    longint ux, uy, sx, sy, lc, ur, sr;
    longint two_w, max_s, min_s;
    res_t   r;
    two_w = longint'(1) << W;
    max_s = (longint'(1) << (W - 1)) - 1;
    min_s = -(longint'(1) << (W - 1));
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lc = c;
    if (op_e'(s) == SUB) begin
      ur     = ux - uy - lc;
      sr     = sx - sy - lc;
      r.cout = (ur >= 0);
    end else begin
      ur     = ux + uy + lc;
      sr     = sx + sy + lc;
      r.cout = (ur >= two_w);
    end
    r.z    = ur[W-1:0];
    r.ovf  = (sr > max_s) || (sr < min_s);
    r.zero = (r.z == '0);
    return r;
  endfunction

  res_t held_v;
  logic held = 1'b0;

  always @(negedge clk) begin
    res_t cur;
    cur = {z, cout, ovf, zero};
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) check("stall_hold", {out_valid, cur}, {1'b1, held_v});
      if (out_valid && out_ready) begin
        check("result_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("result", cur, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
      held   = out_valid && !out_ready;
      held_v = cur;
    end
  end

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, in_ready, 1);
  endtask

  task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic c);
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk); #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic c, input res_t want);
    int unsigned lat;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check(tag, {z, cout, ovf, zero}, want);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [W-1:0] x, y;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; out_ready8 = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_outputs", {out_valid, z, cout, ovf, zero}, '0);
    check("rst_outputs8", {out_valid8, z8, cout8, ovf8, zero8}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    check("idle_outputs", {out_valid, z, cout, ovf, zero}, '0);
    @(posedge clk); #1;

    directed("wrap_add",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    directed("ovf_add",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    directed("sub",        32'd5,         32'd7, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    directed("sub_borrow", 32'd5,         32'd7, 1'b1, 1'b1, {32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0});
    directed("sub_equal",  32'd9,         32'd9, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    directed("ovf_sub",    32'h8000_0000, 32'h1, 1'b1, 1'b0, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    directed("add_cin",    32'hFFFF_FFFE, 32'h1, 1'b0, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});

    // Eight back-to-back bundles; output stalled for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send("stream", $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("stall_full", {in_ready, out_valid}, 2'b01);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          check("resume_rate", out_valid, 1);
        end
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("stream_drained", exp_q.size(), 0);

    // Random backpressure on a longer stream.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send("bp", $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("bp_drained", exp_q.size(), 0);

    // Three bundles in flight, then an asynchronous reset.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send("flush", $urandom(), $urandom(), 1'b0, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("flush_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("flush_async", {out_valid, z, cout, ovf, zero}, '0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("flush_stale", n, 0);
    @(posedge clk); #1;
    x = $urandom();
    y = $urandom();
    directed("post_flush", x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));

    // Single-stage 8-bit instance.
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_ready", in_ready8, 1);
    check("w8_idle", out_valid8, 0);
    @(posedge clk); #1 in_valid8 = 1'b0;
    check("w8_latency", out_valid8, 1);
    check("w8_result", {z8, cout8, ovf8, zero8}, {8'h00, 1'b1, 1'b1, 1'b1});
    @(posedge clk); #1;
    check("w8_drain", out_valid8, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
